idli_instr_deser_m: RTL and testbench
=====================================

IDLI_INSTR_DESER_M -- requirements
Module: idli_instr_deser_m

Interface
REQ-001 SHALL have parameter LANE_W, default 4, bits of encoding per beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter INSTR_W, default 16, assembled instruction width; must be a multiple of LANE_W, and INSTR_W/LANE_W >= 2.
REQ-003 SHALL have parameter DEPTH, default 2, output buffer entries; legal range 1..8.
REQ-004 SHALL derive BEATS = INSTR_W/LANE_W.
REQ-005 i_ids_gck  input  1  clock; one clock domain, all state on its rising edge.
REQ-006 i_ids_rst_n  input  1  reset, synchronous, active-low.
REQ-007 i_ids_enc  input  LANE_W  encoding beat from memory.
REQ-008 i_ids_enc_vld  input  1  beat valid.
REQ-009 o_ids_enc_rdy  output  1  beat accepted this cycle when high together with i_ids_enc_vld.
REQ-010 i_ids_flush  input  1  discard the partial instruction and all buffered instructions.
REQ-011 o_ids_instr  output  INSTR_W  instruction at the buffer head.
REQ-012 o_ids_instr_vld  output  1  buffer non-empty.
REQ-013 i_ids_instr_rdy  input  1  consumer pops the head when high with o_ids_instr_vld.
REQ-014 o_ids_busy  output  1  partial instruction in progress (beat counter non-zero).

Function
REQ-015 A beat SHALL be accepted only when i_ids_enc_vld && o_ids_enc_rdy.
REQ-016 The first accepted beat of an instruction SHALL form bits [INSTR_W-1:INSTR_W-LANE_W]; each later beat fills the next lower LANE_W bits (MSB first).
REQ-017 A beat counter SHALL run 0..BEATS-1, increment on each accepted beat, and wrap to 0 after the final beat.
REQ-018 Gaps (i_ids_enc_vld low) SHALL be allowed mid-instruction; they hold the counter and the partial word.
REQ-019 On the final beat, the assembled word SHALL be written to the buffer tail in the same edge; o_ids_instr_vld rises the following cycle (latency 1 cycle from final beat).
REQ-020 o_ids_enc_rdy SHALL be low only when the counter equals BEATS-1 and the buffer holds DEPTH entries; the value SHALL NOT depend on i_ids_instr_rdy.
REQ-021 The buffer SHALL be FIFO-ordered, with an occupancy count 0..DEPTH and read/write pointers wrapping modulo DEPTH (DEPTH need not be a power of two).
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order; this includes occupancy 1, where the new word becomes head next cycle.
REQ-023 Pop with empty buffer SHALL be ignored; no pointer or count change.
REQ-024 o_ids_instr SHALL present the head entry combinationally from storage; value when empty is the last stored content (zero after reset).
REQ-025 i_ids_flush SHALL, on the next edge, clear the counter, partial word, pointers and occupancy, and SHALL take priority over a same-cycle beat or pop (both discarded).
REQ-026 o_ids_enc_rdy SHALL be high in a cycle with i_ids_flush asserted; the accepted beat is still discarded.
REQ-027 o_ids_busy SHALL equal (counter != 0).

Reset
REQ-028 With i_ids_rst_n low at a rising edge, counter, partial word, pointers, occupancy and all storage entries SHALL become 0.
REQ-029 During and immediately after reset: o_ids_instr_vld=0, o_ids_busy=0, o_ids_enc_rdy=1, o_ids_instr=0.
REQ-030 Reset mid-instruction SHALL discard the partial word; the next accepted beat is treated as beat 0.
REQ-031 Reset SHALL take priority over i_ids_flush and all handshakes.

Verification
REQ-032 Defaults, i_ids_instr_rdy=0; beats A,B,C,D on 4 consecutive cycles -> o_ids_instr=16'hABCD, o_ids_instr_vld=1 one cycle after beat D; busy high for 3 cycles.
REQ-033 Defaults, i_ids_instr_rdy=0; three instructions 1111,2222,3333 -> o_ids_enc_rdy low on the 4th beat of 3333 until one pop, then 3333 completes; pops yield 1111,2222,3333 in order.
REQ-034 Defaults; beats 1,2 then vld low 5 cycles then 3,4 -> single word 16'h1234; counter held during gap.
REQ-035 Defaults; two words buffered, partial beats 5,6, assert i_ids_flush with vld and rdy high -> next cycle vld=0, busy=0; next beats 7,8,9,A -> 16'h789A.
REQ-036 LANE_W=8, INSTR_W=32, DEPTH=3; continuous beats with i_ids_instr_rdy=1 -> one word every 4 cycles, occupancy never exceeds 1, push/pop same cycle correct.
REQ-037 Defaults; assert i_ids_rst_n low after beat 2 of an instruction -> next four beats E,F,0,1 assemble 16'hEF01.

Source files
------------

// File: rtl/idli_instr_deser_if.sv
// Beat-in / instruction-out handshake bundle for the instruction deserialiser.
// slave is the deserialiser side; master is the environment (memory + consumer).
interface idli_instr_deser_if #(
  parameter int LANE_W  = 4,
  parameter int INSTR_W = 16
);
  logic [LANE_W-1:0]  i_ids_enc;
  logic               i_ids_enc_vld;
  logic               o_ids_enc_rdy;
  logic               i_ids_flush;
  logic [INSTR_W-1:0] o_ids_instr;
  logic               o_ids_instr_vld;
  logic               i_ids_instr_rdy;
  logic               o_ids_busy;

  modport slave (
    input  i_ids_enc,
    input  i_ids_enc_vld,
    output o_ids_enc_rdy,
    input  i_ids_flush,
    output o_ids_instr,
    output o_ids_instr_vld,
    input  i_ids_instr_rdy,
    output o_ids_busy
  );

  modport master (
    output i_ids_enc,
    output i_ids_enc_vld,
    input  o_ids_enc_rdy,
    output i_ids_flush,
    input  o_ids_instr,
    input  o_ids_instr_vld,
    output i_ids_instr_rdy,
    input  o_ids_busy
  );
endinterface

// File: rtl/idli_instr_deser_m.sv
// Assembles LANE_W-bit encoding beats (MSB first) into INSTR_W-bit instructions
// and queues them in a small DEPTH-entry FIFO for the consumer.
module idli_instr_deser_m #(
  parameter int LANE_W  = 4,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 2
) (
  input logic               i_ids_gck,
  input logic               i_ids_rst_n,
  idli_instr_deser_if.slave ids
);
  localparam int BEATS  = INSTR_W / LANE_W;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W  = $clog2(DEPTH + 1);
  localparam int PART_W = INSTR_W - LANE_W;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PART_W-1:0] part_q, part_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;

  logic               last_beat;
  logic               full;
  logic               enc_rdy;
  logic               beat_acc;
  logic               push;
  logic               pop;
  logic [INSTR_W-1:0] word;
  logic [INSTR_W-1:0] mem_rd [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Earlier beats shift up as each new beat lands in the low lane.
  assign word      = {part_q, ids.i_ids_enc};
  assign last_beat = (cnt_q == LAST_CNT);
  assign full      = (occ_q == FULL_OCC);
  assign enc_rdy   = ids.i_ids_flush | ~(last_beat & full);
  assign beat_acc  = ids.i_ids_enc_vld & enc_rdy & ~ids.i_ids_flush;
  assign push      = beat_acc & last_beat;
  assign pop       = ids.i_ids_instr_rdy & (occ_q != '0) & ~ids.i_ids_flush;

  always_comb begin
    cnt_d    = cnt_q;
    part_d   = part_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (ids.i_ids_flush) begin
      cnt_d    = '0;
      part_d   = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (beat_acc) begin
        if (last_beat) begin
          cnt_d  = '0;
          part_d = '0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          part_d = word[PART_W-1:0];
        end
      end
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge i_ids_gck) begin
    if (!i_ids_rst_n) begin
      cnt_q    <= '0;
      part_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      part_q   <= part_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage entries survive a flush; only reset clears their contents.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [INSTR_W-1:0] entry_q, entry_d;

    always_comb begin
      entry_d = entry_q;
      if (push && (wr_ptr_q == PTR_W'(gi))) entry_d = word;
    end

    always_ff @(posedge i_ids_gck) begin
      if (!i_ids_rst_n) entry_q <= '0;
      else              entry_q <= entry_d;
    end

    assign mem_rd[gi] = entry_q;
  end

  assign ids.o_ids_enc_rdy   = enc_rdy;
  assign ids.o_ids_instr     = mem_rd[rd_ptr_q];
  assign ids.o_ids_instr_vld = (occ_q != '0);
  assign ids.o_ids_busy      = (cnt_q != '0);
endmodule

// File: tb/tb_idli_instr_deser_m.sv
// Directed bench for the instruction deserialiser: default instance against a
// queue-based model, plus an 8/32/3 instance streaming with the consumer always ready.
module tb_idli_instr_deser_m;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst2_n;

  idli_instr_deser_if #(.LANE_W(4), .INSTR_W(16)) ifa ();
  idli_instr_deser_if #(.LANE_W(8), .INSTR_W(32)) ifb ();

  idli_instr_deser_m dut_a (
    .i_ids_gck   (clk),
    .i_ids_rst_n (rst_n),
    .ids         (ifa)
  );

  idli_instr_deser_m #(.LANE_W(8), .INSTR_W(32), .DEPTH(3)) dut_b (
    .i_ids_gck   (clk),
    .i_ids_rst_n (rst2_n),
    .ids         (ifb)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of instance A: a queue of finished words and the partial beat state.
  logic [15:0] m_q[$];
  int          m_cnt  = 0;
  logic [15:0] m_part = '0;
  bit          m_live = 1'b0;
  bit          m_rdy;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_cnt  = 0;
      m_part = '0;
      m_live = 1'b1;
    end else if (ifa.i_ids_flush) begin
      m_q.delete();
      m_cnt  = 0;
      m_part = '0;
    end else begin
      m_rdy = !(m_cnt == 3 && m_q.size() == 2);
      if (ifa.i_ids_instr_rdy && m_q.size() > 0) void'(m_q.pop_front());
      if (ifa.i_ids_enc_vld && m_rdy) begin
        m_part[4*(3-m_cnt) +: 4] = ifa.i_ids_enc;
        m_cnt++;
        if (m_cnt == 4) begin
          m_q.push_back(m_part);
          m_cnt  = 0;
          m_part = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live && rst_n) begin
      chk("a_enc_rdy", {31'd0, ifa.o_ids_enc_rdy},
          {31'd0, ifa.i_ids_flush || !(m_cnt == 3 && m_q.size() == 2)});
      chk("a_instr_vld", {31'd0, ifa.o_ids_instr_vld}, {31'd0, m_q.size() > 0});
      chk("a_busy", {31'd0, ifa.o_ids_busy}, {31'd0, m_cnt != 0});
      if (m_q.size() > 0) chk("a_instr", {16'd0, ifa.o_ids_instr}, {16'd0, m_q[0]});
    end
  end

  // Sends one beat, holding it until the handshake completes (bounded).
  task automatic beat(input logic [3:0] v);
    bit acc;
    acc = 1'b0;
    ifa.i_ids_enc     = v;
    ifa.i_ids_enc_vld = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      acc = ifa.o_ids_enc_rdy;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("beat_timeout", 32'd0, 32'd1);
    ifa.i_ids_enc_vld = 1'b0;
  endtask

  task automatic beats16(input logic [15:0] w);
    for (int b = 0; b < 4; b++) beat(w[15-4*b -: 4]);
  endtask

  task automatic pop(input logic [15:0] exp);
    chk("pop_vld", {31'd0, ifa.o_ids_instr_vld}, 32'd1);
    chk("pop_data", {16'd0, ifa.o_ids_instr}, {16'd0, exp});
    ifa.i_ids_instr_rdy = 1'b1;
    @(posedge clk);
    #1;
    ifa.i_ids_instr_rdy = 1'b0;
  endtask

  // Instance B: continuous stream with the consumer always ready.
  logic [31:0] eb_q[$];
  int  b_cyc       = 0;
  int  b_last      = -1;
  int  b_words     = 0;
  bit  b_prev_vld  = 1'b0;
  bit  b_done      = 1'b0;

  initial begin
    ifb.i_ids_enc       = '0;
    ifb.i_ids_enc_vld   = 1'b0;
    ifb.i_ids_flush     = 1'b0;
    ifb.i_ids_instr_rdy = 1'b0;
    for (int k = 0; k < 6; k++) eb_q.push_back(32'h1020_3040 + k * 32'h0101_0101);
    wait (rst2_n === 1'b1);
    @(posedge clk);
    #1;
    ifb.i_ids_instr_rdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [31:0] w;
      w = 32'h1020_3040 + k * 32'h0101_0101;
      for (int b = 0; b < 4; b++) begin
        ifb.i_ids_enc     = w[31-8*b -: 8];
        ifb.i_ids_enc_vld = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    ifb.i_ids_enc_vld = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("b_words", b_words, 32'd6);
    b_done = 1'b1;
  end

  always @(negedge clk) begin
    if (rst2_n === 1'b1) begin
      chk("b_enc_rdy", {31'd0, ifb.o_ids_enc_rdy}, 32'd1);
      chk("b_occ_le1", {31'd0, ifb.o_ids_instr_vld && b_prev_vld}, 32'd0);
      if (ifb.o_ids_instr_vld) begin
        if (eb_q.size() == 0) chk("b_extra_word", 32'd1, 32'd0);
        else chk("b_instr", ifb.o_ids_instr, eb_q.pop_front());
        if (b_last >= 0) chk("b_spacing", b_cyc - b_last, 32'd4);
        b_last = b_cyc;
        b_words++;
      end
      b_prev_vld = ifb.o_ids_instr_vld;
      b_cyc++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.i_ids_enc       = '0;
    ifa.i_ids_enc_vld   = 1'b0;
    ifa.i_ids_flush     = 1'b0;
    ifa.i_ids_instr_rdy = 1'b0;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    chk("rst_vld", {31'd0, ifa.o_ids_instr_vld}, 32'd0);
    chk("rst_busy", {31'd0, ifa.o_ids_busy}, 32'd0);
    chk("rst_enc_rdy", {31'd0, ifa.o_ids_enc_rdy}, 32'd1);
    chk("rst_instr", {16'd0, ifa.o_ids_instr}, 32'd0);

    // Back-to-back A,B,C,D
    beat(4'hA);
    chk("abcd_busy_a", {31'd0, ifa.o_ids_busy}, 32'd1);
    beat(4'hB);
    beat(4'hC);
    chk("abcd_busy_c", {31'd0, ifa.o_ids_busy}, 32'd1);
    beat(4'hD);
    chk("abcd_busy_d", {31'd0, ifa.o_ids_busy}, 32'd0);
    chk("abcd_vld", {31'd0, ifa.o_ids_instr_vld}, 32'd1);
    chk("abcd_instr", {16'd0, ifa.o_ids_instr}, 32'h0000_ABCD);
    pop(16'hABCD);

    // Backpressure on the final beat of the third word
    beats16(16'h1111);
    beats16(16'h2222);
    beat(4'h3);
    beat(4'h3);
    beat(4'h3);
    fork
      beat(4'h3);
      begin
        repeat (3) @(posedge clk);
        #1;
        chk("bp_enc_rdy_low", {31'd0, ifa.o_ids_enc_rdy}, 32'd0);
        chk("bp_busy", {31'd0, ifa.o_ids_busy}, 32'd1);
        pop(16'h1111);
        pop(16'h2222);
      end
    join
    pop(16'h3333);
    chk("bp_empty", {31'd0, ifa.o_ids_instr_vld}, 32'd0);

    // Gap mid-instruction
    beat(4'h1);
    beat(4'h2);
    repeat (5) @(posedge clk);
    #1;
    chk("gap_busy_held", {31'd0, ifa.o_ids_busy}, 32'd1);
    beat(4'h3);
    beat(4'h4);
    pop(16'h1234);

    // Flush with buffered words, a partial word, a beat and a pop all at once
    beats16(16'h4321);
    beats16(16'h8765);
    beat(4'h5);
    beat(4'h6);
    ifa.i_ids_flush     = 1'b1;
    ifa.i_ids_enc       = 4'h7;
    ifa.i_ids_enc_vld   = 1'b1;
    ifa.i_ids_instr_rdy = 1'b1;
    #1;
    chk("flush_enc_rdy", {31'd0, ifa.o_ids_enc_rdy}, 32'd1);
    @(posedge clk);
    #1;
    ifa.i_ids_flush     = 1'b0;
    ifa.i_ids_enc_vld   = 1'b0;
    ifa.i_ids_instr_rdy = 1'b0;
    chk("flush_vld", {31'd0, ifa.o_ids_instr_vld}, 32'd0);
    chk("flush_busy", {31'd0, ifa.o_ids_busy}, 32'd0);
    beats16(16'h789A);
    pop(16'h789A);

    // Flush while stalled: ready must be forced high during the flush
    beats16(16'h0F0F);
    beats16(16'hF0F0);
    beat(4'h9);
    beat(4'h9);
    beat(4'h9);
    chk("stall_enc_rdy", {31'd0, ifa.o_ids_enc_rdy}, 32'd0);
    ifa.i_ids_flush = 1'b1;
    #1;
    chk("stall_flush_rdy", {31'd0, ifa.o_ids_enc_rdy}, 32'd1);
    @(posedge clk);
    #1;
    ifa.i_ids_flush = 1'b0;
    chk("stall_flush_vld", {31'd0, ifa.o_ids_instr_vld}, 32'd0);
    chk("stall_flush_busy", {31'd0, ifa.o_ids_busy}, 32'd0);

    // Reset mid-instruction
    beat(4'h1);
    beat(4'h2);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("mrst_instr", {16'd0, ifa.o_ids_instr}, 32'd0);
    chk("mrst_vld", {31'd0, ifa.o_ids_instr_vld}, 32'd0);
    chk("mrst_busy", {31'd0, ifa.o_ids_busy}, 32'd0);
    chk("mrst_enc_rdy", {31'd0, ifa.o_ids_enc_rdy}, 32'd1);
    beats16(16'hEF01);
    pop(16'hEF01);

    for (int k = 0; k < 400 && !b_done; k++) @(posedge clk);
    if (!b_done) chk("b_done_timeout", 32'd0, 32'd1);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
